mul_arb_sched: RTL and testbench
================================

# mul_arb_sched

Scheduler that shares one pipelined `array_multiplier` (operands `m`/`q`, product `p`, fixed pipeline latency `LAT`) among `NREQ` requesters. It runs a per-requester valid/ready handshake, picks one requester per cycle, and registers that requester's operands onto the multiplier inputs. It tags each issued operation with the requester index and carries the tag alongside the multiplier pipeline. When the product emerges, it returns the product with its tag. The block sits between the client datapaths and the multiplier instance; the multiplier itself stays outside the block.

## Interface
- `NREQ`, 4: number of requesters, 2..16
- `WIDTHM`, 4: multiplicand width
- `WIDTHQ`, 4: multiplier width
- `WIDTHP`, 8: product width, = `WIDTHM+WIDTHQ`
- `LAT`, 3: cycles from `mul_m_o`/`mul_q_o` to `mul_product_i` of the multiplier instance
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid_i`  in  NREQ  request k has operands pending
- `req_ready_o`  out  NREQ  one-hot grant; a transfer happens when `valid[k] & ready[k]`
- `req_m_i`  in  NREQ*WIDTHM  packed multiplicands, slice k = requester k
- `req_q_i`  in  NREQ*WIDTHQ  packed multipliers
- `hold_i`  in  1  stop issuing new operations; in-flight operations complete
- `mul_m_o`  out  WIDTHM  registered operand to the multiplier
- `mul_q_o`  out  WIDTHQ  registered operand to the multiplier
- `mul_product_i`  in  WIDTHP  multiplier result
- `rsp_valid_o`  out  1  result strobe, 1 cycle
- `rsp_id_o`  out  $clog2(NREQ)  requester index of the result
- `rsp_product_o`  out  WIDTHP  product
- `drained_o`  out  1  no operation is in flight anywhere in the block or the multiplier

## Operation
- Arbitration is combinational from `req_valid_i`, `hold_i` and the priority pointer.
- At most one `req_ready_o` bit is high. No bit is high if `hold_i`=1, if `rst`=1, or if no request is valid.
- `req_ready_o[k]` is high only when `req_valid_i[k]` is high, so every grant is a transfer.
- On a transfer, the selected slices are registered into `mul_m_o`/`mul_q_o`, and the tag {valid=1, id=k} enters the tag pipeline.
- With no transfer, `mul_m_o`/`mul_q_o` are registered to 0 and a tag with valid=0 enters.
- The tag pipeline has depth `LAT`, aligned with the multiplier. Its output, together with `mul_product_i`, is registered into `rsp_*`.
- When the tag is invalid, `rsp_valid_o`=0 and `rsp_id_o`/`rsp_product_o` are 0.
- There is no response backpressure. Clients must accept `rsp_*` whenever it is valid; the multiplier has no stall.
- The FSM has three states:
  - IDLE: no tag in flight. Go to BUSY on a transfer.
  - BUSY: tags in flight. Go to DRAIN when `hold_i`=1. Go to IDLE when no tag is in flight and there is no transfer.
  - DRAIN: `hold_i`=1 and tags are in flight. Go to IDLE when the last tag has retired. Go to BUSY if `hold_i` drops while tags are still in flight.
- `drained_o` = (state==IDLE), registered.
- Arithmetic is unsigned. The block never alters the product.

## Timing
- A transfer in cycle t puts the operands on `mul_m_o`/`mul_q_o` in cycle t+1. The product is on `mul_product_i` in cycle t+1+LAT, and `rsp_valid_o` is high in cycle t+2+LAT (5 for LAT=3).
- Throughput is one operation per cycle. Back-to-back transfers produce back-to-back responses in issue order.
- Reset values: `req_ready_o`=0, `mul_m_o`=0, `mul_q_o`=0, `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_product_o`=0, `drained_o`=1, pointer=0, all tags invalid, state IDLE.
- Reset mid-operation discards all in-flight tags. No response appears for any operation accepted before `rst`, even though the external multiplier still flushes its data.
- `hold_i` rising in the same cycle as a request: no transfer in that cycle.
- The pointer advances only on a transfer.

## Configuration
- `MUL_ARB_SCHED_RR_EN` defined: round-robin arbitration.
  - The search starts at the pointer.
  - After a grant to k, the pointer becomes (k+1) mod NREQ, wrapping from NREQ-1 to 0.
- Not defined: fixed priority, lowest index wins. The pointer register is removed.

## Structure
- Package `mul_arb_pkg` holds:
  - function `id_w(n)` = max(1, $clog2(n))
  - typedef `tag_t` struct {valid, id}
  - FSM state enum `mul_arb_state_e` {IDLE, BUSY, DRAIN}
- Sub-module `mul_arb_tag_pipe`: parameterised shift register of `tag_t`, depth `LAT`, synchronous active-high clear. It outputs the tail tag and an any-valid flag, which is used by the FSM.
- The arbiter logic and response register stay in the top module.

## Test plan
- Reset check: hold `rst` 3 cycles with all `req_valid_i`=1 -> every output at its reset value and `req_ready_o`=0; first grant to requester 0 in the cycle after `rst` falls.
- Single request: requester 2 sends m=6, q=14 in cycle t -> `mul_m_o`=6, `mul_q_o`=14 at t+1; `rsp_valid_o`=1, `rsp_id_o`=2, `rsp_product_o`=84 at t+5 (LAT=3).
- Round-robin, macro on: all 4 valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses arrive in the same order with the correct products, e.g. 15*15=225.
- Fixed priority, macro off: requesters 1 and 3 valid for 4 cycles -> requester 1 granted every cycle and requester 3 never.
- Drain: stream requests, raise `hold_i` -> `req_ready_o`=0 the same cycle; the remaining ≤LAT+1 responses still arrive; `drained_o` rises 1 cycle after the last `rsp_valid_o`.
- Reset mid-flight: 3 operations issued, `rst` pulsed 1 cycle later -> no `rsp_valid_o` for those operations; normal operation resumes afterwards.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types and helpers for the multiplier-sharing scheduler
// Contents: id_w() index width helper, tag_t in-flight tag, mul_arb_state_e FSM states
package mul_arb_pkg;
    // Widest requester index the tag must carry (NREQ <= 16)
    localparam int ID_MAX_W = 4;

    function automatic int id_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} mul_arb_state_e;
endpackage

// File: rtl/mul_arb_tag_pipe.sv
// mul_arb_tag_pipe: LAT-deep tag shift register kept in step with the external multiplier
// Ports: clk, rst (sync, active-high clear), tag_i (tag entering with the operands),
//        tag_o (tag leaving with the product), any_o (some stage holds a valid tag)
module mul_arb_tag_pipe
    import mul_arb_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t tag_o,
    output logic any_o
);
    tag_t stage_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    always_comb begin
        any_o = 1'b0;
        for (int i = 0; i < LAT; i++) any_o = any_o | stage_q[i].valid;
    end

    assign tag_o = stage_q[LAT-1];
endmodule

// File: rtl/mul_arb_sched.sv
// mul_arb_sched: shares one pipelined multiplier among NREQ valid/ready requesters
// Ports: clk, rst (sync, active-high); req_valid_i/req_ready_o (one-hot grant),
//        req_m_i/req_q_i (packed operand slices); hold_i (stop issuing);
//        mul_m_o/mul_q_o -> multiplier, mul_product_i <- multiplier (LAT cycles later);
//        rsp_valid_o/rsp_id_o/rsp_product_o (1-cycle result strobe); drained_o (nothing in flight)
// Config: MUL_ARB_SCHED_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module mul_arb_sched
    import mul_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WIDTHM = 4,
    parameter int WIDTHQ = 4,
    parameter int WIDTHP = WIDTHM + WIDTHQ,
    parameter int LAT    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [NREQ*WIDTHM-1:0]   req_m_i,
    input  logic [NREQ*WIDTHQ-1:0]   req_q_i,
    input  logic                     hold_i,
    output logic [WIDTHM-1:0]        mul_m_o,
    output logic [WIDTHQ-1:0]        mul_q_o,
    input  logic [WIDTHP-1:0]        mul_product_i,
    output logic                     rsp_valid_o,
    output logic [id_w(NREQ)-1:0]    rsp_id_o,
    output logic [WIDTHP-1:0]        rsp_product_o,
    output logic                     drained_o
);
    localparam int IDW = id_w(NREQ);

    logic [IDW-1:0]    sel;
    logic              any_req, xfer, inflight, pipe_any;
    logic [WIDTHM-1:0] mul_m_q, mul_m_d;
    logic [WIDTHQ-1:0] mul_q_q, mul_q_d;
    tag_t              tag_q, tag_d, tail;
    mul_arb_state_e    state_q, state_d;
    logic              drained_q, rsp_valid_q;
    logic [IDW-1:0]    rsp_id_q;
    logic [WIDTHP-1:0] rsp_product_q;

`ifdef MUL_ARB_SCHED_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v >= NREQ ? v - NREQ : v);
    endfunction

    // Scan offsets from farthest to nearest so the requester at the pointer wins last
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid_i[wrap(int'(ptr_q) + i)]) begin
                sel     = wrap(int'(ptr_q) + i);
                any_req = 1'b1;
            end
        end
    end

    assign ptr_d = xfer ? wrap(int'(sel) + 1) : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                sel     = IDW'(i);
                any_req = 1'b1;
            end
        end
    end
`endif

    assign xfer        = any_req & ~hold_i & ~rst;
    assign req_ready_o = xfer ? (NREQ'(1) << sel) : '0;
    assign mul_m_d     = xfer ? req_m_i[sel*WIDTHM +: WIDTHM] : '0;
    assign mul_q_d     = xfer ? req_q_i[sel*WIDTHQ +: WIDTHQ] : '0;
    assign tag_d       = '{valid: xfer, id: xfer ? ID_MAX_W'(sel) : '0};

    // tag_q rides with the operand register, the pipe covers the multiplier's LAT stages
    mul_arb_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_q),
        .tag_o (tail),
        .any_o (pipe_any)
    );

    assign inflight = tag_q.valid | pipe_any;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = xfer ? BUSY : IDLE;
            BUSY:    state_d = hold_i ? (inflight ? DRAIN : IDLE) : ((inflight || xfer) ? BUSY : IDLE);
            DRAIN:   state_d = !inflight ? (xfer ? BUSY : IDLE) : (hold_i ? DRAIN : BUSY);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            drained_q     <= 1'b1;
            mul_m_q       <= '0;
            mul_q_q       <= '0;
            tag_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
        end else begin
            state_q       <= state_d;
            drained_q     <= (state_d == IDLE);
            mul_m_q       <= mul_m_d;
            mul_q_q       <= mul_q_d;
            tag_q         <= tag_d;
            rsp_valid_q   <= tail.valid;
            rsp_id_q      <= tail.valid ? tail.id[IDW-1:0] : '0;
            rsp_product_q <= tail.valid ? mul_product_i : '0;
        end
    end

    assign mul_m_o       = mul_m_q;
    assign mul_q_o       = mul_q_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_product_o = rsp_product_q;
    assign drained_o     = drained_q;
endmodule

// File: tb/tb_mul_arb_sched.sv
// tb_mul_arb_sched: randomized scoreboard bench for mul_arb_sched with a behavioural multiplier
module tb_mul_arb_sched;
    localparam int NREQ   = 4;
    localparam int WIDTHM = 4;
    localparam int WIDTHQ = 4;
    localparam int WIDTHP = 8;
    localparam int LAT    = 3;
    localparam int IDW    = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid_i = '1;
    logic [NREQ-1:0]        req_ready_o;
    logic [NREQ*WIDTHM-1:0] req_m_i = '0;
    logic [NREQ*WIDTHQ-1:0] req_q_i = '0;
    logic                   hold_i = 1'b0;
    logic [WIDTHM-1:0]      mul_m_o;
    logic [WIDTHQ-1:0]      mul_q_o;
    logic [WIDTHP-1:0]      mul_product_i;
    logic                   rsp_valid_o;
    logic [IDW-1:0]         rsp_id_o;
    logic [WIDTHP-1:0]      rsp_product_o;
    logic                   drained_o;

    mul_arb_sched #(.NREQ(NREQ), .WIDTHM(WIDTHM), .WIDTHQ(WIDTHQ), .WIDTHP(WIDTHP), .LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_m_i       (req_m_i),
        .req_q_i       (req_q_i),
        .hold_i        (hold_i),
        .mul_m_o       (mul_m_o),
        .mul_q_o       (mul_q_o),
        .mul_product_i (mul_product_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_id_o      (rsp_id_o),
        .rsp_product_o (rsp_product_o),
        .drained_o     (drained_o)
    );

    always #5 clk = ~clk;

    // External multiplier: LAT register stages, no stall
    logic [WIDTHP-1:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= mul_m_o * mul_q_o;
        p2 <= p1;
        p3 <= p2;
    end
    assign mul_product_i = p3;

    typedef struct {
        int id;
        int prod;
        int due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_x = -100;
    int   ptr = 0;
    int   exp_m = 0;
    int   exp_q = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle the response port must match the head of the scoreboard or be idle
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid_o), 1);
            chk("rsp_id", 32'(rsp_id_o), e.id);
            chk("rsp_product", 32'(rsp_product_o), e.prod);
        end else begin
            chk("rsp_idle", {rsp_valid_o, 7'd0, rsp_id_o, rsp_product_o}, 0);
        end
    end

    task automatic step(input logic r, input logic h, input logic [NREQ-1:0] v,
                        input logic [NREQ*WIDTHM-1:0] mv, input logic [NREQ*WIDTHQ-1:0] qv);
        int gid;
        int exp_rdy;
        logic [WIDTHM-1:0] mm;
        logic [WIDTHQ-1:0] qq;
        @(posedge clk);
        #1;
        chk("mul_m", 32'(mul_m_o), exp_m);
        chk("mul_q", 32'(mul_q_o), exp_q);
        chk("drained", 32'(drained_o), (cyc - last_x > LAT + 2) ? 1 : 0);
        #1;
        rst = r;
        hold_i = h;
        req_valid_i = v;
        req_m_i = mv;
        req_q_i = qv;
        if (r) while (sb.size() != 0 && sb[$].due > cyc) void'(sb.pop_back());
        #1;
        gid = -1;
        if (!r && !h) begin
`ifdef MUL_ARB_SCHED_RR_EN
            for (int o = NREQ - 1; o >= 0; o--) if (v[(ptr + o) % NREQ]) gid = (ptr + o) % NREQ;
`else
            for (int k = NREQ - 1; k >= 0; k--) if (v[k]) gid = k;
`endif
        end
        exp_rdy = (gid >= 0) ? (1 << gid) : 0;
        chk("req_ready", 32'(req_ready_o), exp_rdy);
        if (gid >= 0) begin
            mm = mv[gid*WIDTHM +: WIDTHM];
            qq = qv[gid*WIDTHQ +: WIDTHQ];
            exp_m = int'(mm);
            exp_q = int'(qq);
            sb.push_back('{id: gid, prod: int'(mm) * int'(qq), due: cyc + LAT + 2});
            last_x = cyc;
            ptr = (gid + 1) % NREQ;
        end else begin
            exp_m = 0;
            exp_q = 0;
        end
        if (r) begin
            last_x = -100;
            ptr = 0;
        end
    endtask

    function automatic logic [NREQ*WIDTHM-1:0] rnd_m();
        return (NREQ*WIDTHM)'($urandom);
    endfunction

    function automatic logic [NREQ*WIDTHQ-1:0] rnd_q();
        return (NREQ*WIDTHQ)'($urandom);
    endfunction

    initial begin
        logic [NREQ*WIDTHM-1:0] mv;
        logic [NREQ*WIDTHQ-1:0] qv;
        // Reset with every requester asking, then first grant must go to requester 0
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '1, rnd_m(), rnd_q());
        step(1'b0, 1'b0, '1, rnd_m(), rnd_q());
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, '0);
        // Single request from requester 2: 6 * 14 = 84
        mv = '0;
        qv = '0;
        mv[2*WIDTHM +: WIDTHM] = WIDTHM'(6);
        qv[2*WIDTHQ +: WIDTHQ] = WIDTHQ'(14);
        step(1'b0, 1'b0, 4'b0100, mv, qv);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, '0, '0);
        // All requesters with max operands for 8 cycles
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '1, '1, '1);
        // Requesters 1 and 3 only
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b1010, rnd_m(), rnd_q());
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, '0);
        // Stream then hold: in-flight work must retire, drained rises afterwards
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '1, rnd_m(), rnd_q());
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '1, rnd_m(), rnd_q());
        step(1'b0, 1'b0, '0, '0, '0);
        // Three issued, reset one cycle later: those responses must never appear
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '1, rnd_m(), rnd_q());
        step(1'b1, 1'b0, '1, rnd_m(), rnd_q());
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, '0);
        // Random traffic with occasional hold and reset
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                 NREQ'($urandom), rnd_m(), rnd_q());
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, '0, '0);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
